// File: rtl/prog_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// prog_sequencer : program store + fetch/issue sequencer for the 9-bit bus
//                  processor (mvi immediate supply, halt opcodes, watchdog).
// Revision       : 1.0
// ============================================================================
module prog_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int WD_LIMIT = 7
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [8:0]        load_data,
    input  logic              done,
    output logic [8:0]        DIN,
    output logic              run,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        instr_count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int WD_W  = (WD_LIMIT > 2) ? $clog2(WD_LIMIT) : 1;
    // Last WAIT count before the watchdog fires; the HALT then lands exactly
    // WD_LIMIT cycles after the run pulse.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_nx;
    logic [7:0]        cnt_nx;
    logic              err_nx;
    logic [2:0]        op_q, op_nx;
    logic [WD_W-1:0]   wd, wd_nx;
    logic              mem_we;
    logic [8:0]        mem [DEPTH];

    // Program store is deliberately not reset so a reset keeps the program.
    always_ff @(posedge clock) begin
        if (mem_we)
            mem[load_addr] <= load_data;
    end

    assign DIN    = mem[pc];
    assign busy   = (state == S_FETCH) || (state == S_WAIT);
    assign halted = (state == S_HALT);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr_count <= '0;
            err         <= 1'b0;
            op_q        <= '0;
            wd          <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            instr_count <= cnt_nx;
            err         <= err_nx;
            op_q        <= op_nx;
            wd          <= wd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        cnt_nx   = instr_count;
        err_nx   = err;
        op_nx    = op_q;
        wd_nx    = wd;
        run      = 1'b0;
        mem_we   = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                mem_we = load_en;
                if (start) begin
                    pc_nx    = '0;
                    cnt_nx   = '0;
                    err_nx   = 1'b0;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                if (DIN[8]) begin
                    state_nx = S_HALT;
                end else begin
                    run      = 1'b1;
                    op_nx    = DIN[8:6];
                    pc_nx    = pc + 1'b1;
                    wd_nx    = '0;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done) begin
                    // mvi consumed the word at pc as its immediate; skip it.
                    if (op_q == 3'd1)
                        pc_nx = pc + 1'b1;
                    if (instr_count != 8'hFF)
                        cnt_nx = instr_count + 8'd1;
                    state_nx = S_FETCH;
                end else if (wd == WD_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = S_HALT;
                end else begin
                    wd_nx = wd + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_prog_sequencer : directed self-checking bench with a behavioural model of
//                     the 9-bit processor answering run/done.
// Revision          : 1.0
// ============================================================================
module tb_prog_sequencer;

    localparam int ADDR_W   = 5;
    localparam int WD_LIMIT = 7;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [8:0]        load_data = '0;
    logic              done;
    logic [8:0]        DIN;
    logic              run, busy, halted, err;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        instr_count;

    int checks = 0;
    int failures = 0;

    prog_sequencer #(.ADDR_W(ADDR_W), .WD_LIMIT(WD_LIMIT)) dut (
        .clock(clock), .resetn(resetn), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .done(done),
        .DIN(DIN), .run(run), .busy(busy), .halted(halted), .err(err),
        .pc(pc), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    // Processor model: mv/mvi answer in T1, add/sub in T3; mute holds done low.
    logic [8:0] ir = '0;
    logic [3:0] tstep = '0;
    logic       active = 1'b0;
    logic       mute = 1'b0;
    logic [8:0] R [8];

    initial for (int i = 0; i < 8; i++) R[i] = '0;

    assign done = active && !mute &&
                  ((ir[8:7] == 2'b00 && tstep == 4'd1) ||
                   (ir[8:7] == 2'b01 && tstep == 4'd3));

    always @(posedge clock) begin
        if (run) begin
            ir     <= DIN;
            tstep  <= 4'd1;
            active <= 1'b1;
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
                case (ir[8:6])
                    3'd0: R[ir[5:3]] <= R[ir[2:0]];
                    3'd1: R[ir[5:3]] <= DIN;
                    3'd2: R[ir[5:3]] <= R[ir[5:3]] + R[ir[2:0]];
                    3'd3: R[ir[5:3]] <= R[ir[5:3]] - R[ir[2:0]];
                    default: ;
                endcase
            end else if (tstep != 4'hF) begin
                tstep <= tstep + 4'd1;
            end
        end
    end

    // All tasks start and end just after a falling edge.
    task automatic load_word(input logic [ADDR_W-1:0] a, input logic [8:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clock);
        load_en = 1'b0;
    endtask

    task automatic load_prog1();
        load_word(5'd0, 9'h040);
        load_word(5'd1, 9'h005);
        load_word(5'd2, 9'h008);
        load_word(5'd3, 9'h081);
        load_word(5'd4, 9'h1C0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_halt(input int max_cycles);
        for (int i = 0; i < max_cycles && !halted; i++) @(negedge clock);
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_timeout: halted=%b expected 1 within %0d cycles", halted, max_cycles);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        checks++;
        if ({run, busy, halted, err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: run/busy/halted/err=%b expected 0000", {run, busy, halted, err});
        end
        checks++;
        if (pc !== 5'd0 || instr_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_regs: pc=%0d cnt=%0d expected 0 0", pc, instr_count);
        end
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_program();
        load_prog1();
        pulse_start();
        for (int c = 1; c <= 10; c++) begin
            logic exp_run;
            exp_run = (c == 1 || c == 3 || c == 5);
            checks++;
            if (run !== exp_run) begin
                failures++;
                $display("FAIL prog_run_c%0d: run=%b expected %b", c, run, exp_run);
            end
            if (c == 2) begin
                checks++;
                if (DIN !== 9'h005) begin
                    failures++;
                    $display("FAIL prog_imm: DIN=%h expected 005", DIN);
                end
            end
            if (c == 9) begin
                checks++;
                if (busy !== 1'b1 || pc !== 5'd4) begin
                    failures++;
                    $display("FAIL prog_c9: busy=%b pc=%0d expected 1 4", busy, pc);
                end
            end
            if (c == 10) begin
                checks++;
                if (halted !== 1'b1 || pc !== 5'd4 || instr_count !== 8'd3 || err !== 1'b0) begin
                    failures++;
                    $display("FAIL prog_halt: halted=%b pc=%0d cnt=%0d err=%b expected 1 4 3 0",
                             halted, pc, instr_count, err);
                end
                checks++;
                if (R[0] !== 9'd10 || R[1] !== 9'd5) begin
                    failures++;
                    $display("FAIL prog_regs: R0=%0d R1=%0d expected 10 5", R[0], R[1]);
                end
            end
            if (c != 10) @(negedge clock);
        end
    endtask

    task automatic test_watchdog();
        pulse_start();
        for (int c = 1; c < 5; c++) @(negedge clock);
        checks++;
        if (run !== 1'b1 || DIN !== 9'h081) begin
            failures++;
            $display("FAIL wd_add_issue: run=%b DIN=%h expected 1 081", run, DIN);
        end
        mute = 1'b1;
        for (int c = 6; c <= 11; c++) begin
            @(negedge clock);
            checks++;
            if (busy !== 1'b1 || halted !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL wd_wait_c%0d: busy=%b halted=%b err=%b expected 1 0 0", c, busy, halted, err);
            end
        end
        @(negedge clock);
        checks++;
        if (err !== 1'b1 || halted !== 1'b1 || pc !== 5'd4) begin
            failures++;
            $display("FAIL wd_fire: err=%b halted=%b pc=%0d expected 1 1 4", err, halted, pc);
        end
        mute = 1'b0;
    endtask

    task automatic test_wrap();
        int guard;
        load_word(5'd0, 9'h033);
        for (int a = 1; a < 31; a++) load_word(5'(a), 9'h000);
        load_word(5'd31, 9'h040);
        pulse_start();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL wrap_err_clear: err=%b expected 0", err);
        end
        guard = 0;
        while (!(run === 1'b1 && DIN === 9'h040) && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        checks++;
        if (pc !== 5'd31 || run !== 1'b1) begin
            failures++;
            $display("FAIL wrap_issue: pc=%0d run=%b expected 31 1", pc, run);
        end
        @(negedge clock);
        checks++;
        if (DIN !== 9'h033 || pc !== 5'd0) begin
            failures++;
            $display("FAIL wrap_imm: DIN=%h pc=%0d expected 033 0", DIN, pc);
        end
        @(negedge clock);
        checks++;
        if (pc !== 5'd1 || instr_count !== 8'd32 || R[0] !== 9'h033) begin
            failures++;
            $display("FAIL wrap_skip: pc=%0d cnt=%0d R0=%h expected 1 32 033", pc, instr_count, R[0]);
        end
        mute = 1'b1;
        wait_halt(20);
        mute = 1'b0;
    endtask

    task automatic test_load_guard();
        for (int a = 0; a < 4; a++) load_word(5'(a), 9'h000);
        load_word(5'd4, 9'h1C0);
        pulse_start();
        load_word(5'd3, 9'h1FF);
        wait_halt(50);
        checks++;
        if (pc !== 5'd4 || instr_count !== 8'd4) begin
            failures++;
            $display("FAIL load_busy_ignored: pc=%0d cnt=%0d expected 4 4", pc, instr_count);
        end
        load_word(5'd3, 9'h1FF);
        pulse_start();
        wait_halt(50);
        checks++;
        if (pc !== 5'd3 || instr_count !== 8'd3) begin
            failures++;
            $display("FAIL load_halt_taken: pc=%0d cnt=%0d expected 3 3", pc, instr_count);
        end
        load_en = 1'b1; load_addr = 5'd0; load_data = 9'h1C0;
        start = 1'b1;
        @(negedge clock);
        load_en = 1'b0; start = 1'b0;
        checks++;
        if (run !== 1'b0 || busy !== 1'b1 || DIN !== 9'h1C0) begin
            failures++;
            $display("FAIL start_load_fetch: run=%b busy=%b DIN=%h expected 0 1 1C0", run, busy, DIN);
        end
        @(negedge clock);
        checks++;
        if (halted !== 1'b1 || pc !== 5'd0 || instr_count !== 8'd0) begin
            failures++;
            $display("FAIL start_load_halt: halted=%b pc=%0d cnt=%0d expected 1 0 0", halted, pc, instr_count);
        end
    endtask

    task automatic test_reset_mid();
        load_prog1();
        pulse_start();
        for (int c = 1; c < 7; c++) @(negedge clock);
        checks++;
        if (busy !== 1'b1 || run !== 1'b0 || pc !== 5'd4) begin
            failures++;
            $display("FAIL rstmid_pre: busy=%b run=%b pc=%0d expected 1 0 4", busy, run, pc);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({run, busy, halted, err} !== 4'b0000 || pc !== 5'd0 || instr_count !== 8'd0) begin
            failures++;
            $display("FAIL rstmid_async: flags=%b pc=%0d cnt=%0d expected 0000 0 0",
                     {run, busy, halted, err}, pc, instr_count);
        end
        checks++;
        if (DIN !== 9'h040) begin
            failures++;
            $display("FAIL rstmid_mem: DIN=%h expected 040", DIN);
        end
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        pulse_start();
        wait_halt(30);
        checks++;
        if (pc !== 5'd4 || instr_count !== 8'd3 || R[0] !== 9'd10) begin
            failures++;
            $display("FAIL rstmid_rerun: pc=%0d cnt=%0d R0=%0d expected 4 3 10", pc, instr_count, R[0]);
        end
    endtask

    task automatic test_saturate();
        for (int a = 0; a < 32; a++) load_word(5'(a), 9'h000);
        pulse_start();
        for (int i = 0; i < 200; i++) @(negedge clock);
        checks++;
        if (instr_count !== 8'd100 || run !== 1'b1) begin
            failures++;
            $display("FAIL sat_mid: cnt=%0d run=%b expected 100 1", instr_count, run);
        end
        for (int i = 0; i < 400; i++) @(negedge clock);
        checks++;
        if (instr_count !== 8'd255) begin
            failures++;
            $display("FAIL sat_top: cnt=%0d expected 255", instr_count);
        end
        mute = 1'b1;
        wait_halt(20);
        mute = 1'b0;
        checks++;
        if (instr_count !== 8'd255 || err !== 1'b1) begin
            failures++;
            $display("FAIL sat_end: cnt=%0d err=%b expected 255 1", instr_count, err);
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_watchdog();
        test_wrap();
        test_load_guard();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
